// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state/owner encodings and helpers for the byte-wide RAM sequencer.
package mem_ctrl_pkg;
    localparam int MC_ADDR_W = 32;

    typedef enum logic [1:0] {MC_IDLE, MC_RD, MC_WR, MC_DONE} mc_state_e;
    typedef enum logic {MC_OWN_IF, MC_OWN_DATA} mc_owner_e;

    // Read issues lane 3 twice so its byte can land one cycle later.
    function automatic logic [1:0] mc_lane_clamp(input logic [2:0] cnt);
        return cnt > 3'd3 ? 2'd3 : cnt[1:0];
    endfunction
endpackage

// File: rtl/mc_byte_asm.sv
// mc_byte_asm: picks one byte lane out of a word and rebuilds the word with that lane replaced.
module mc_byte_asm (
    input  logic [31:0] word,
    input  logic [1:0]  idx,
    input  logic [7:0]  byte_in,
    output logic [7:0]  byte_out,
    output logic [31:0] word_out
);
    always_comb begin
        word_out = word;
        word_out[8*idx +: 8] = byte_in;
    end

    assign byte_out = word[8*idx +: 8];
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates fetch and data word requests onto a single-port byte-wide RAM.
// Optional MEM_CTRL_FETCH_HIT_EN adds a one-entry fetch tag that skips repeated fetches.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W     = MC_ADDR_W,
    parameter int RAM_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_data,
    output logic              if_busy,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [3:0]        mem_mask,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_data,
    output logic              mem_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    input  logic [7:0]        ram_rdata
);
    localparam logic [2:0] RD_LAT  = 3'(RAM_RD_LAT);
    localparam logic [2:0] RD_LAST = 3'(3 + RAM_RD_LAT);

    mc_state_e         state, state_n;
    mc_owner_e         owner, owner_n;
    logic [2:0]        cnt, cnt_n;
    logic [ADDR_W-1:0] base, base_n, if_base, mem_base;
    logic [3:0]        mask_q;
    logic [31:0]       wdata_q, lane_word, rd_word;
    logic [1:0]        lane_idx;
    logic [7:0]        wr_byte;
    logic              hit, capture, unused_addr;

    assign if_base     = {if_addr[ADDR_W-1:2], 2'b00};
    assign mem_base    = {mem_addr[ADDR_W-1:2], 2'b00};
    assign unused_addr = ^{if_addr[1:0], mem_addr[1:0]};

`ifdef MEM_CTRL_FETCH_HIT_EN
    logic [ADDR_W-1:0] last_if_base;
    logic              valid;

    assign hit = valid && last_if_base == if_base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid        <= 1'b0;
            last_if_base <= '0;
        end else if (state == MC_IDLE && mem_write && mem_base == last_if_base) begin
            valid <= 1'b0;
        end else if (state == MC_RD && owner == MC_OWN_IF && cnt == RD_LAST) begin
            valid        <= 1'b1;
            last_if_base <= base;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        state_n = state;
        owner_n = owner;
        base_n  = base;
        cnt_n   = cnt + 3'd1;
        case (state)
            MC_IDLE: begin
                cnt_n = '0;
                if (mem_write || mem_read) begin
                    state_n = mem_write ? MC_WR : MC_RD;
                    owner_n = MC_OWN_DATA;
                    base_n  = mem_base;
                end else if (if_req) begin
                    state_n = hit ? MC_DONE : MC_RD;
                    owner_n = MC_OWN_IF;
                    base_n  = if_base;
                end
            end
            MC_RD:   state_n = cnt == RD_LAST ? MC_DONE : MC_RD;
            MC_WR:   state_n = cnt == 3'd3 ? MC_DONE : MC_WR;
            default: begin
                state_n = MC_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= MC_IDLE;
            owner   <= MC_OWN_DATA;
            cnt     <= '0;
            base    <= '0;
            mask_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            cnt   <= cnt_n;
            base  <= base_n;
            if (state == MC_IDLE && mem_write) begin
                mask_q  <= mem_mask;
                wdata_q <= mem_wdata;
            end
        end
    end

    // One assembler serves both directions: serialises wdata_q on writes, merges read bytes otherwise.
    assign lane_word = state == MC_WR ? wdata_q : owner == MC_OWN_IF ? if_data : mem_data;
    assign lane_idx  = state == MC_WR ? cnt[1:0] : 2'(cnt - RD_LAT);
    assign capture   = state == MC_RD && cnt >= RD_LAT;

    mc_byte_asm u_asm (
        .word     (lane_word),
        .idx      (lane_idx),
        .byte_in  (ram_rdata),
        .byte_out (wr_byte),
        .word_out (rd_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_data  <= '0;
            mem_data <= '0;
        end else if (capture) begin
            if (owner == MC_OWN_IF) if_data <= rd_word;
            else mem_data <= rd_word;
        end
    end

    assign ram_addr  = state == MC_RD ? base + ADDR_W'(mc_lane_clamp(cnt)) :
                       state == MC_WR ? base + ADDR_W'(cnt[1:0]) : '0;
    assign ram_wdata = state == MC_WR ? wr_byte : '0;
    assign ram_we    = state == MC_WR && mask_q[cnt[1:0]];

    assign mem_busy = (mem_read || mem_write) && !(state == MC_DONE && owner == MC_OWN_DATA);
    assign if_busy  = if_req && !(state == MC_DONE && owner == MC_OWN_IF);
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl with a transaction-level model and a byte RAM.
module tb_mem_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        if_req = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
    logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
    logic [3:0]  mem_mask = '0;
    logic [31:0] if_data, mem_data, ram_addr;
    logic        if_busy, mem_busy, ram_we;
    logic [7:0]  ram_wdata, ram_rdata;

    int checks = 0, errors = 0;

`ifdef MEM_CTRL_FETCH_HIT_EN
    localparam int REFETCH_STALLS = 1;
`else
    localparam int REFETCH_STALLS = 6;
`endif

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_data   (if_data),
        .if_busy   (if_busy),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_mask  (mem_mask),
        .mem_wdata (mem_wdata),
        .mem_data  (mem_data),
        .mem_busy  (mem_busy),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte RAM with one-cycle read latency; preloaded with a known pattern.
    logic [7:0] ram [1024];
    initial begin
        for (int a = 0; a < 1024; a++) ram[a] = 8'(a * 7 + 3);
        ram[256] = 8'h11; ram[257] = 8'h22; ram[258] = 8'h33; ram[259] = 8'h44;
        forever begin
            @(posedge clk);
            if (ram_we) ram[ram_addr[9:0]] <= ram_wdata;
            ram_rdata <= ram[ram_addr[9:0]];
        end
    end

    // Transaction model: each accepted request lasts a fixed number of stalled cycles then one release cycle.
    logic [7:0]  shadow [1024];
    bit          active, own_if, is_wr, done;
    int          n, stall, k;
    logic [31:0] t_base, t_wd, m_if, m_mem, e_addr, word;
    logic [3:0]  t_mask;
    logic [7:0]  e_wd;
    logic        e_we, e_ifb, e_memb;
`ifdef MEM_CTRL_FETCH_HIT_EN
    bit          tag_v;
    logic [31:0] tag;
`endif
    initial forever begin
        @(negedge clk);
        done = 0; e_addr = '0; e_we = 1'b0; e_wd = '0;
        if (!rst_n) begin
            active = 0; m_if = '0; m_mem = '0;
            for (int a = 0; a < 1024; a++) shadow[a] = ram[a];
`ifdef MEM_CTRL_FETCH_HIT_EN
            tag_v = 0;
`endif
        end else begin
            if (!active && (mem_write || mem_read || if_req)) begin
                active = 1; n = 0; is_wr = mem_write; own_if = !(mem_write || mem_read);
                t_base = own_if ? {if_addr[31:2], 2'b00} : {mem_addr[31:2], 2'b00};
                t_mask = mem_mask; t_wd = mem_wdata; stall = is_wr ? 5 : 6;
`ifdef MEM_CTRL_FETCH_HIT_EN
                if (own_if && tag_v && tag == t_base) stall = 1;
                if (is_wr && tag == t_base) tag_v = 0;
`endif
            end
            if (active) begin
                n++;
                done = n == stall + 1;
                if (stall > 1 && n >= 2 && n <= stall) begin
                    k = n - 2;
                    if (is_wr) begin
                        e_addr = t_base + k; e_we = t_mask[k]; e_wd = t_wd[8*k +: 8];
                    end else e_addr = t_base + (k > 3 ? 3 : k);
                end
            end
        end
        e_ifb  = if_req && !(done && own_if);
        e_memb = (mem_read || mem_write) && !(done && !own_if);
        if (done) begin
            if (is_wr) begin
                for (int j = 0; j < 4; j++)
                    if (t_mask[j]) shadow[t_base[9:0] + 10'(j)] = t_wd[8*j +: 8];
            end else begin
                word = {shadow[t_base[9:0] + 10'd3], shadow[t_base[9:0] + 10'd2],
                        shadow[t_base[9:0] + 10'd1], shadow[t_base[9:0]]};
                if (own_if) m_if = word; else m_mem = word;
`ifdef MEM_CTRL_FETCH_HIT_EN
                if (own_if) begin tag_v = 1; tag = t_base; end
`endif
            end
        end
        chk("if_busy", 32'(if_busy), 32'(e_ifb));
        chk("mem_busy", 32'(mem_busy), 32'(e_memb));
        chk("ram_we", 32'(ram_we), 32'(e_we));
        chk("ram_addr", ram_addr, e_addr);
        chk("ram_wdata", 32'(ram_wdata), 32'(e_wd));
        if (!active || done) begin
            chk("if_data", if_data, m_if);
            chk("mem_data", mem_data, m_mem);
        end
        if (done) active = 0;
    end

    task automatic run(input bit fetch, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [3:0] m, input logic [31:0] wd, output int stalls);
        @(posedge clk); #1;
        if_req = fetch; if_addr = a; mem_read = rd; mem_write = wr;
        mem_addr = a; mem_mask = m; mem_wdata = wd;
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fetch ? if_busy : mem_busy) stalls++;
            else break;
        end
        @(posedge clk); #1;
        if_req = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    endtask

    int          st, ifb, memst;
    bit          dm, di;
    logic [31:0] seq [14];
    logic [31:0] exp_seq [10] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd7};

    initial begin
        #22 rst_n = 1'b1;
        @(negedge clk);
        chk("reset mem_data", mem_data, 32'h0);
        chk("reset if_data", if_data, 32'h0);
        chk("reset ram_we", 32'(ram_we), 32'h0);
        chk("reset ram_addr", ram_addr, 32'h0);

        run(0, 1, 0, 32'h100, 4'h0, 32'h0, st);
        chk("read stalls", st, 6);
        chk("read word", mem_data, 32'h44332211);

        run(0, 0, 1, 32'h203, 4'b1000, 32'hAB000000, st);
        chk("sb write stalls", st, 5);
        chk("sb byte 200", 32'(ram[512]), 32'h03);
        chk("sb byte 201", 32'(ram[513]), 32'h0A);
        chk("sb byte 202", 32'(ram[514]), 32'h11);
        chk("sb byte 203", 32'(ram[515]), 32'hAB);
        chk("write keeps mem_data", mem_data, 32'h44332211);

        run(0, 1, 1, 32'h204, 4'b0101, 32'h00770066, st);
        chk("rd+wr is write stalls", st, 5);
        chk("rd+wr byte 204", 32'(ram[516]), 32'h66);

        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h0; mem_read = 1'b1; mem_addr = 32'h40;
        ifb = 0; memst = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (if_busy) ifb++;
            if (mem_read && mem_busy) memst++;
            dm = mem_read && !mem_busy;
            di = !if_busy;
            @(posedge clk); #1;
            if (dm) mem_read = 1'b0;
            if (di) begin if_req = 1'b0; break; end
        end
        chk("arb if_busy cycles", ifb, 13);
        chk("arb mem stalls", memst, 6);
        chk("arb mem_data", mem_data, 32'hD8D1CAC3);
        chk("arb if_data", if_data, 32'h18110A03);

        run(0, 0, 1, 32'h0, 4'hF, 32'h18110A03, st);
        chk("rewrite stalls", st, 5);

        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            seq[i] = ram_addr;
            @(posedge clk); #1;
            if (i == 6) if_addr = 32'h4;
        end
        if_req = 1'b0;
        for (int j = 0; j < 10; j++) chk("b2b ram_addr", seq[j < 5 ? j + 1 : j + 3], exp_seq[j]);
        chk("b2b if_data", if_data, 32'h342D261F);

        run(1, 0, 0, 32'h8, 4'h0, 32'h0, st);
        chk("fetch8 stalls", st, 6);
        chk("fetch8 data", if_data, 32'h5049423B);
        run(1, 0, 0, 32'h8, 4'h0, 32'h0, st);
        chk("refetch8 stalls", st, REFETCH_STALLS);
        run(0, 0, 1, 32'h8, 4'hF, 32'h5049423B, st);
        chk("write8 stalls", st, 5);
        run(1, 0, 0, 32'h8, 4'h0, 32'h0, st);
        chk("fetch8 after write stalls", st, 6);
        chk("fetch8 after write data", if_data, 32'h5049423B);

        @(posedge clk); #1;
        mem_write = 1'b1; mem_addr = 32'h300; mem_mask = 4'hF; mem_wdata = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        #1;
        chk("wr cnt2 ram_we", 32'(ram_we), 32'h1);
        chk("wr cnt2 ram_addr", ram_addr, 32'h302);
        #1;
        rst_n = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        chk("rst mid-wr ram_we", 32'(ram_we), 32'h0);
        chk("rst mid-wr ram_addr", ram_addr, 32'h0);
        chk("rst mid-wr mem_data", mem_data, 32'h0);
        chk("rst mid-wr if_data", if_data, 32'h0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        run(0, 1, 0, 32'h100, 4'h0, 32'h0, st);
        chk("post-rst read stalls", st, 6);
        chk("post-rst read word", mem_data, 32'h44332211);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Arbitrates and sequences the byte-wide external RAM between the fetch port (IF) and the data port (MEM stage).
- Converts each 32-bit word request into four byte transfers.
- Drives `busy` back to each requester so the pipeline stalls until its transfer completes.
- Sits between the core's IF/MEM stages and the single-port 8-bit RAM.

Parameters:
- ADDR_W, 32, width of requester and RAM addresses
- RAM_RD_LAT, 1, RAM read latency in cycles; only 1 is supported

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request
- if_addr  in  ADDR_W  fetch address; bits [1:0] ignored
- if_data  out  32  fetched word, little-endian
- if_busy  out  1  fetch stall
- mem_read  in  1  data read request
- mem_write  in  1  data write request
- mem_addr  in  ADDR_W  data address; bits [1:0] ignored
- mem_mask  in  4  byte write enables
- mem_wdata  in  32  write data, already lane-aligned
- mem_data  out  32  read word, little-endian
- mem_busy  out  1  data stall
- ram_addr  out  ADDR_W  byte address to RAM
- ram_wdata  out  8  byte to RAM
- ram_we  out  1  RAM write strobe
- ram_rdata  in  8  byte from RAM, valid one cycle after ram_addr

Behaviour:
- Reset values: FSM = IDLE, cnt = 0, owner = DATA. All data/address outputs are 0, ram_we = 0.
- `if_busy` and `mem_busy` are combinational, so the requester stalls in the same cycle the request appears.
- States: IDLE, RD, WR, DONE. Registers: `base = {addr[ADDR_W-1:2],2'b00}`, `cnt[2:0]`, `owner`, `mask_q`, `wdata_q`.
- IDLE:
  - If mem_write: owner = DATA, go to WR.
  - Else if mem_read: owner = DATA, go to RD.
  - Else if if_req: owner = IF, go to RD.
  - Data port strictly wins when both ports request simultaneously; IF stays stalled.
  - mem_read and mem_write both high: write wins.
- RD, cnt 0..4:
  - ram_addr = base + min(cnt,3).
  - When cnt ≥ 1, byte cnt-1 is captured from ram_rdata into lane cnt-1 of the owner's output register.
  - After cnt = 4, go to DONE.
  - Read occupancy is 5 cycles in RD.
- WR, cnt 0..3:
  - ram_addr = base + cnt, ram_wdata = wdata_q[8*cnt+:8], ram_we = mask_q[cnt].
  - Every lane is visited regardless of mask.
  - After cnt = 3, go to DONE.
- DONE (1 cycle):
  - Owner's busy is low; the owner's output register holds the complete word.
  - Next state is IDLE.
- Busy equations:
  - mem_busy = (mem_read | mem_write) & !(state == DONE & owner == DATA)
  - if_busy = if_req & !(state == DONE & owner == IF)
- Latency from request in IDLE to busy low:
  - Read: 6 stalled cycles, released in cycle 7.
  - Write: 5 stalled cycles, released in cycle 6.
- if_data and mem_data hold their value until that port's next read completes. A data write never changes mem_data.
- A request still asserted in IDLE after its own DONE is serviced again. Repeating a write of identical data is harmless; the pipeline must drop its request when busy falls.
- Request inputs are sampled only in IDLE. A change during RD/WR has no effect on the transfer in flight.
- RST asserted mid-WR: ram_we drops immediately and the partially written word stays in RAM. Software treats this as undefined.
- ram_we is low in every state except WR.

Optional Feature:
- MEM_CTRL_FETCH_HIT_EN:
  - Adds a one-entry fetch tag (`last_if_base`, `valid`).
  - In IDLE, if if_req is the only request and the word matches a valid tag, go directly to DONE: if_busy stalls 1 cycle, no RAM access.
  - Any data write whose base equals the tag clears `valid`; reset clears `valid`.
- Without the macro: every fetch takes the full RD sequence.

Decomposition:
- Shared package/header (config.vh):
  - State encodings MC_IDLE/MC_RD/MC_WR/MC_DONE.
  - Owner encoding MC_OWN_IF/MC_OWN_DATA.
  - ADDR width macro reused.
- One sub-module, `mc_byte_asm`: a 32-bit lane assembler/serialiser, byte index in, byte in/out, shared by the RD capture and WR select paths.

Test Plan:
- Data read at 0x100, RAM bytes 11,22,33,44 -> mem_busy high for 6 cycles, then mem_data = 0x44332211.
- SB-style write mem_addr = 0x203, mask 4'b1000, wdata 0xAB000000 -> ram_we only when ram_addr = 0x203; bytes 0x200..0x202 unchanged.
- if_req and mem_read both raised at 0x0 and 0x40 in the same cycle -> data serviced first; if_busy high for 13 cycles; if_data = word@0x0.
- Back-to-back fetches 0x0 and 0x4 -> two full RD sequences; ram_addr sequence 0,1,2,3,3,4,5,6,7,7.
- RST low during WR cnt = 2 -> ram_we = 0 in that cycle, state IDLE, outputs 0; after release a new read succeeds.
- With MEM_CTRL_FETCH_HIT_EN:
  - Refetch 0x8 -> 1 stall cycle, no ram_addr activity.
  - Write 0x8 then fetch 0x8 -> full 6-cycle read.
